// File: rtl/proc_pkg.sv
// Shared instruction field positions, opcode/aluop constants and the multdiv FSM state type.
package proc_pkg;

  localparam int unsigned OPC_MSB   = 31;
  localparam int unsigned OPC_LSB   = 27;
  localparam int unsigned RD_MSB    = 26;
  localparam int unsigned RD_LSB    = 22;
  localparam int unsigned RS_MSB    = 21;
  localparam int unsigned RS_LSB    = 17;
  localparam int unsigned RT_MSB    = 16;
  localparam int unsigned RT_LSB    = 12;
  localparam int unsigned ALUOP_MSB = 6;
  localparam int unsigned ALUOP_LSB = 2;

  localparam logic [4:0] OP_ALU  = 5'd0;
  localparam logic [4:0] OP_BNE  = 5'd2;
  localparam logic [4:0] OP_JR   = 5'd4;
  localparam logic [4:0] OP_ADDI = 5'd5;
  localparam logic [4:0] OP_BLT  = 5'd6;
  localparam logic [4:0] OP_SW   = 5'd7;
  localparam logic [4:0] OP_LW   = 5'd8;

  localparam logic [4:0] ALU_MUL = 5'd6;
  localparam logic [4:0] ALU_DIV = 5'd7;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_MD_WAIT = 1'b1
  } md_state_t;

endpackage

// File: rtl/stall_control_if.sv
// Multdiv handshake between the stall controller (master) and the multdiv unit (slave).
interface stall_control_if;
  logic ctrl_mult;
  logic ctrl_div;
  logic md_abort;
  logic md_ready;
  logic md_exception;

  modport master (
    output ctrl_mult,
    output ctrl_div,
    output md_abort,
    input  md_ready,
    input  md_exception
  );

  modport slave (
    input  ctrl_mult,
    input  ctrl_div,
    input  md_abort,
    output md_ready,
    output md_exception
  );
endinterface

// File: rtl/src_reg_decode.sv
// Source-register decode: which of rs/rt/rd an instruction reads, plus the register fields.
module src_reg_decode
  import proc_pkg::*;
(
  input  logic [31:0] i_instr,
  output logic        o_read_rs,
  output logic        o_read_rt,
  output logic        o_read_rd,
  output logic [4:0]  o_rs,
  output logic [4:0]  o_rt,
  output logic [4:0]  o_rd
);

  logic [4:0] w_opcode;
  logic       w_unused_bits;

  assign w_opcode      = i_instr[OPC_MSB:OPC_LSB];
  assign o_rd          = i_instr[RD_MSB:RD_LSB];
  assign o_rs          = i_instr[RS_MSB:RS_LSB];
  assign o_rt          = i_instr[RT_MSB:RT_LSB];
  assign w_unused_bits = ^i_instr[RT_LSB-1:0];

  always_comb begin
    o_read_rs = 1'b0;
    o_read_rt = 1'b0;
    o_read_rd = 1'b0;
    case (w_opcode)
      OP_ALU: begin
        o_read_rs = 1'b1;
        o_read_rt = 1'b1;
      end
      // sw store data (rd) is left out: lw-to-sw data is forwarded at memory
      OP_ADDI, OP_LW, OP_SW: o_read_rs = 1'b1;
      OP_BNE, OP_BLT: begin
        o_read_rs = 1'b1;
        o_read_rd = 1'b1;
      end
      OP_JR:   o_read_rd = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/stall_control.sv
// Pipeline stall control: load-use bubble, multdiv start/wait with watchdog abort, branch flush.
// Defining STALL_PERF_CNT_EN adds a saturating stall_cycles counter output.
module stall_control
  import proc_pkg::*;
#(
  parameter int unsigned MD_TIMEOUT = 63
)(
  input  logic            clock,
  input  logic            reset_n,
  input  logic [31:0]     FDIR,
  input  logic [31:0]     DXIR,
  input  logic            branch_taken,
  stall_control_if.master md,
  output logic            stall_pc,
  output logic            stall_fd,
  output logic            stall_dx,
  output logic            nop_dx,
  output logic            flush_fd,
  output logic            flush_dx
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]     stall_cycles
`endif
);

  localparam logic [7:0] TIMEOUT_CNT = 8'(MD_TIMEOUT);

  logic       w_fd_read_rs, w_fd_read_rt, w_fd_read_rd;
  logic [4:0] w_fd_rs, w_fd_rt, w_fd_rd;
  logic [4:0] w_dx_opcode, w_dx_rd, w_dx_aluop;
  logic       w_dx_lw, w_dx_mul, w_dx_div, w_load_use;
  logic       w_md_done, w_timeout;
  logic       w_ctrl_mult, w_ctrl_div, w_md_abort;
  logic       w_unused_dx;
  md_state_t  r_state, w_state_nxt;
  logic [7:0] r_count, w_count_nxt;

  src_reg_decode u_fd_decode (
    .i_instr   (FDIR),
    .o_read_rs (w_fd_read_rs),
    .o_read_rt (w_fd_read_rt),
    .o_read_rd (w_fd_read_rd),
    .o_rs      (w_fd_rs),
    .o_rt      (w_fd_rt),
    .o_rd      (w_fd_rd)
  );

  assign w_dx_opcode = DXIR[OPC_MSB:OPC_LSB];
  assign w_dx_rd     = DXIR[RD_MSB:RD_LSB];
  assign w_dx_aluop  = DXIR[ALUOP_MSB:ALUOP_LSB];
  assign w_unused_dx = ^{DXIR[RS_MSB:ALUOP_MSB+1], DXIR[ALUOP_LSB-1:0]};

  assign w_dx_lw  = (w_dx_opcode == OP_LW);
  assign w_dx_mul = (w_dx_opcode == OP_ALU) && (w_dx_aluop == ALU_MUL);
  assign w_dx_div = (w_dx_opcode == OP_ALU) && (w_dx_aluop == ALU_DIV);

  assign w_load_use = w_dx_lw && (w_dx_rd != '0) &&
                      ((w_fd_read_rs && (w_fd_rs == w_dx_rd)) ||
                       (w_fd_read_rt && (w_fd_rt == w_dx_rd)) ||
                       (w_fd_read_rd && (w_fd_rd == w_dx_rd)));

  assign w_md_done = md.md_ready || md.md_exception;
  assign w_timeout = !w_md_done && (r_count == TIMEOUT_CNT);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      ST_IDLE: begin
        if ((w_dx_mul || w_dx_div) && !branch_taken) begin
          w_state_nxt = ST_MD_WAIT;
          w_count_nxt = '0;
        end
      end
      ST_MD_WAIT: begin
        if (w_md_done || w_timeout) w_state_nxt = ST_IDLE;
        else                        w_count_nxt = r_count + 8'd1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Outputs are gated by reset_n so they drop as soon as reset asserts, not at the next edge.
  always_comb begin
    stall_pc    = 1'b0;
    stall_fd    = 1'b0;
    stall_dx    = 1'b0;
    nop_dx      = 1'b0;
    flush_fd    = 1'b0;
    flush_dx    = 1'b0;
    w_ctrl_mult = 1'b0;
    w_ctrl_div  = 1'b0;
    w_md_abort  = 1'b0;
    if (reset_n) begin
      if (branch_taken) begin
        flush_fd = 1'b1;
        flush_dx = 1'b1;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_dx_mul || w_dx_div) begin
              w_ctrl_mult = w_dx_mul;
              w_ctrl_div  = w_dx_div;
              stall_pc    = 1'b1;
              stall_fd    = 1'b1;
              stall_dx    = 1'b1;
            end else if (w_load_use) begin
              stall_pc = 1'b1;
              stall_fd = 1'b1;
              nop_dx   = 1'b1;
            end
          end
          ST_MD_WAIT: begin
            if (w_timeout) begin
              flush_dx = 1'b1;
            end else if (!w_md_done) begin
              stall_pc = 1'b1;
              stall_fd = 1'b1;
              stall_dx = 1'b1;
            end
          end
          default: ;
        endcase
      end
      w_md_abort = (r_state == ST_MD_WAIT) && w_timeout;
    end
  end

  assign md.ctrl_mult = w_ctrl_mult;
  assign md.ctrl_div  = w_ctrl_div;
  assign md.md_abort  = w_md_abort;

`ifdef STALL_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                            r_stall_cycles <= '0;
    else if (stall_pc && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + 32'd1;
  end

  assign stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_stall_control.sv
// Scoreboard bench for stall_control: directed hazard scenarios plus randomized cycles vs a reference model.
module tb_stall_control;
  import proc_pkg::*;

  localparam int unsigned T = 10;
  // {stall_pc, stall_fd, stall_dx, nop_dx, flush_fd, flush_dx, ctrl_mult, ctrl_div, md_abort}
  localparam logic [8:0] NONE  = 9'b000000000;
  localparam logic [8:0] LU    = 9'b110100000;
  localparam logic [8:0] MDST  = 9'b111000000;
  localparam logic [8:0] MULP  = 9'b111000100;
  localparam logic [8:0] DIVP  = 9'b111000010;
  localparam logic [8:0] FLUSH = 9'b000011000;
  localparam logic [8:0] ABORT = 9'b000001001;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] FDIR, DXIR;
  logic        branch_taken;
  logic        stall_pc, stall_fd, stall_dx, nop_dx, flush_fd, flush_dx;
`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  stall_control_if md_if();

  stall_control #(.MD_TIMEOUT(T)) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .FDIR         (FDIR),
    .DXIR         (DXIR),
    .branch_taken (branch_taken),
    .md           (md_if),
    .stall_pc     (stall_pc),
    .stall_fd     (stall_fd),
    .stall_dx     (stall_dx),
    .nop_dx       (nop_dx),
    .flush_fd     (flush_fd),
    .flush_dx     (flush_dx)
`ifdef STALL_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clock = ~clock;

  int          n_vec  = 0;
  int          n_miss = 0;
  logic [8:0]  exp_q[$];
  string       tag_q[$];

  // Reference model: -1 when no multdiv is outstanding, else wait cycles already spent.
  int          m_wait   = -1;
  int unsigned m_stalls = 0;

  function automatic logic [31:0] mk(input logic [4:0] op, rd, rs, rt, alu);
    return {op, rd, rs, rt, 5'd0, alu, 2'b00};
  endfunction

  function automatic logic [8:0] outs();
    return {stall_pc, stall_fd, stall_dx, nop_dx, flush_fd, flush_dx,
            md_if.ctrl_mult, md_if.ctrl_div, md_if.md_abort};
  endfunction

  function automatic bit reads_reg(input logic [31:0] ins, input logic [4:0] r);
    logic [4:0] op, rd, rs, rt;
    op = ins[31:27]; rd = ins[26:22]; rs = ins[21:17]; rt = ins[16:12];
    case (op)
      5'd0:             return (rs == r) || (rt == r);
      5'd5, 5'd7, 5'd8: return rs == r;
      5'd2, 5'd6:       return (rd == r) || (rs == r);
      5'd4:             return rd == r;
      default:          return 1'b0;
    endcase
  endfunction

  task automatic model_step(input logic [31:0] fd, dx, input logic br, rdy, exc,
                            output logic [8:0] e);
    logic [4:0] dop, drd, dalu;
    bit mul, div;
    dop = dx[31:27]; drd = dx[26:22]; dalu = dx[6:2];
    mul = (dop == 5'd0) && (dalu == 5'd6);
    div = (dop == 5'd0) && (dalu == 5'd7);
    e = NONE;
    if (m_wait < 0) begin
      if (br)       e = FLUSH;
      else if (mul) begin e = MULP; m_wait = 0; end
      else if (div) begin e = DIVP; m_wait = 0; end
      else if (dop == 5'd8 && drd != 5'd0 && reads_reg(fd, drd)) e = LU;
    end else if (rdy || exc) begin
      e = br ? FLUSH : NONE; m_wait = -1;
    end else if (m_wait == int'(T)) begin
      e = br ? (FLUSH | ABORT) : ABORT; m_wait = -1;
    end else begin
      e = br ? FLUSH : MDST; m_wait++;
    end
    if (e[8]) m_stalls++;
  endtask

  task automatic apply(input logic [31:0] fd, dx, input logic br, rdy, exc,
                       input bit use_want, input logic [8:0] want, input string tag);
    logic [8:0] e;
    @(posedge clock); #1;
    FDIR = fd; DXIR = dx; branch_taken = br;
    md_if.md_ready = rdy; md_if.md_exception = exc;
    model_step(fd, dx, br, rdy, exc, e);
    exp_q.push_back(use_want ? want : e);
    tag_q.push_back(tag);
  endtask

  task automatic dir(input logic [31:0] fd, dx, input logic br, rdy, exc,
                     input logic [8:0] want, input string tag);
    apply(fd, dx, br, rdy, exc, 1'b1, want, tag);
  endtask

  task automatic check_now(input logic [8:0] want, input string tag);
    n_vec++;
    if (outs() !== want) begin
      n_miss++;
      $display("FAIL %s: got %b want %b", tag, outs(), want);
    end
  endtask

  initial begin : monitor
    logic [8:0] e;
    string t;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        n_vec++;
        if (outs() !== e) begin
          n_miss++;
          $display("FAIL %s: got %b want %b", t, outs(), e);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: run did not finish, got timeout want finish");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    logic [31:0] mul_i, div_i, fd, dx, held_dx;
    logic [4:0]  ops [9];
    int unsigned sel;
    ops   = '{5'd0, 5'd2, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd1, 5'd3};
    mul_i = mk(5'd0, 5'd3, 5'd1, 5'd2, 5'd6);
    div_i = mk(5'd0, 5'd3, 5'd1, 5'd2, 5'd7);

    reset_n = 1'b0; FDIR = '0; DXIR = mul_i; branch_taken = 1'b0;
    md_if.md_ready = 1'b0; md_if.md_exception = 1'b0;
    #2 check_now(NONE, "reset_outputs");
    DXIR = '0;
    #10 reset_n = 1'b1;

    // load-use detection
    dir(mk(5'd0, 5'd6, 5'd5, 5'd2, 5'd0), mk(5'd8, 5'd5, 5'd1, 5'd0, 5'd0), 0, 0, 0, LU, "loaduse_add");
    dir(mk(5'd0, 5'd6, 5'd5, 5'd2, 5'd0), '0, 0, 0, 0, NONE, "after_bubble");
    dir(mk(5'd0, 5'd6, 5'd0, 5'd0, 5'd0), mk(5'd8, 5'd0, 5'd1, 5'd0, 5'd0), 0, 0, 0, NONE, "lw_r0");
    dir(mk(5'd7, 5'd5, 5'd7, 5'd0, 5'd0), mk(5'd8, 5'd5, 5'd1, 5'd0, 5'd0), 0, 0, 0, NONE, "lw_sw_data");
    dir(mk(5'd2, 5'd5, 5'd1, 5'd0, 5'd0), mk(5'd8, 5'd5, 5'd1, 5'd0, 5'd0), 0, 0, 0, LU, "loaduse_branch_rd");
    dir(mk(5'd4, 5'd5, 5'd0, 5'd0, 5'd0), mk(5'd8, 5'd5, 5'd1, 5'd0, 5'd0), 0, 0, 0, LU, "loaduse_jr");
    dir(mk(5'd5, 5'd6, 5'd5, 5'd0, 5'd0), mk(5'd8, 5'd5, 5'd1, 5'd0, 5'd0), 0, 0, 0, LU, "loaduse_addi");
    dir(mk(5'd0, 5'd6, 5'd1, 5'd5, 5'd0), mk(5'd8, 5'd5, 5'd1, 5'd0, 5'd0), 0, 0, 0, LU, "loaduse_rt");
    dir(mk(5'd5, 5'd5, 5'd1, 5'd0, 5'd0), mk(5'd8, 5'd5, 5'd1, 5'd0, 5'd0), 0, 0, 0, NONE, "addi_dest_only");

    // mul with ready four cycles after issue
    dir('0, mul_i, 0, 0, 0, MULP, "mul_issue");
    for (int i = 0; i < 3; i++) dir('0, mul_i, 0, 0, 0, MDST, "mul_wait");
    dir('0, mul_i, 0, 1, 0, NONE, "mul_ready");
    dir('0, mul_i, 0, 0, 0, MULP, "idle_after_ready");
    dir('0, mul_i, 0, 0, 1, NONE, "mul_exception");
    dir('0, '0, 0, 1, 0, NONE, "ready_in_idle");

    // div watchdog
    dir('0, div_i, 0, 0, 0, DIVP, "div_issue");
    for (int i = 0; i < int'(T); i++) dir('0, div_i, 0, 0, 0, MDST, "div_wait");
    dir('0, div_i, 0, 0, 0, ABORT, "div_abort");
    dir('0, '0, 0, 0, 0, NONE, "idle_after_abort");

    // branch priority
    dir(mk(5'd0, 5'd6, 5'd5, 5'd2, 5'd0), mk(5'd8, 5'd5, 5'd1, 5'd0, 5'd0), 1, 0, 0, FLUSH, "branch_over_loaduse");
    dir('0, mul_i, 1, 0, 0, FLUSH, "branch_blocks_mul");
    dir('0, '0, 0, 0, 0, NONE, "no_wait_after_branch");

    // asynchronous reset while waiting
    dir('0, mul_i, 0, 0, 0, MULP, "rst_mul_issue");
    dir('0, mul_i, 0, 0, 0, MDST, "rst_wait1");
    dir('0, mul_i, 0, 0, 0, MDST, "rst_wait2");
    @(negedge clock); #2;
    reset_n = 1'b0;
    #1 check_now(NONE, "async_reset_in_wait");
    m_wait = -1; m_stalls = 0;
    DXIR = '0;
    @(posedge clock); @(posedge clock); #3;
    reset_n = 1'b1;
    dir('0, '0, 0, 0, 0, NONE, "post_reset_idle0");
    dir('0, '0, 0, 0, 0, NONE, "post_reset_idle1");
    dir('0, mul_i, 0, 0, 0, MULP, "post_reset_mul");
    dir('0, mul_i, 0, 1, 0, NONE, "post_reset_ready");

    // randomized cycles
    held_dx = '0;
    for (int n = 0; n < 1500; n++) begin
      fd = mk(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              5'($urandom_range(0, 3)), 5'($urandom_range(0, 7)));
      if (m_wait >= 0) begin
        apply(fd, held_dx, 1'b0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 15) == 0),
              1'b0, NONE, "rand_wait");
      end else begin
        sel = $urandom_range(0, 9);
        if (sel < 4)       dx = mk(5'd8, 5'($urandom_range(0, 3)), 5'd1, 5'd0, 5'd0);
        else if (sel == 4) dx = mul_i;
        else if (sel == 5) dx = div_i;
        else dx = mk(ops[$urandom_range(0, 8)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 7)));
        apply(fd, dx, ($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'b0, NONE, "rand_idle");
        held_dx = dx;
      end
    end
    while (m_wait >= 0) apply('0, held_dx, 0, 1, 0, 1'b0, NONE, "drain_ready");
    for (int i = 0; i < 3; i++) apply('0, '0, 0, 0, 0, 1'b0, NONE, "drain_idle");

    @(negedge clock); @(negedge clock);
    n_vec++;
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
    end
`ifdef STALL_PERF_CNT_EN
    n_vec++;
    if (stall_cycles !== 32'(m_stalls)) begin
      n_miss++;
      $display("FAIL stall_cycles: got %0d want %0d", stall_cycles, m_stalls);
    end
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
